// File: rtl/mc_fifo_ctrl_pkg.sv
// mc_fifo_ctrl_pkg
// Shared limits and helpers for the multi-queue FIFO controller.
//   FIFO_MAX_WIDTH / FIFO_MAX_DEPTH / MAX_QUEUES : legal parameter ceilings
//   calc_qwidth()                                : width of a queue-select field
package mc_fifo_ctrl_pkg;

  localparam int FIFO_MAX_WIDTH = 2048;
  localparam int FIFO_MAX_DEPTH = 1 << 20;
  localparam int MAX_QUEUES     = 256;

  // A single queue still gets a one-bit select so ports never collapse to zero width.
  function automatic int calc_qwidth(input int num_queues);
    return (num_queues <= 1) ? 1 : $clog2(num_queues);
  endfunction

endpackage

// File: rtl/mc_fifo_ptr_bank.sv
// mc_fifo_ptr_bank
// Per-queue head/tail/count registers, empty/full flags and accept logic for
// the multi-queue FIFO controller.
// Optional feature macro: MC_FIFO_CTRL_OCCUPANCY_EN (adds a registered count readout).
// Ports:
//   clock, rst_n       clock and asynchronous active-low reset
//   wrreq, wr_sel      enqueue request and (already sanitised) target queue
//   rdreq, rd_sel      dequeue request and (already sanitised) source queue
//   wr_acc, rd_acc     accepted enqueue / dequeue this cycle
//   wr_ptr, rd_ptr     tail of wr_sel / head of rd_sel
//   empty, full        per-queue flag bitmaps
//   occ_sel, occ_count occupancy readout (only with the macro defined)
module mc_fifo_ptr_bank #(
  parameter int NUM_QUEUES = 4,
  parameter int DEPTH      = 2048,
  parameter int QWIDTH     = 2,
  parameter int PWIDTH     = 11
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              wrreq,
  input  logic [QWIDTH-1:0] wr_sel,
  input  logic              rdreq,
  input  logic [QWIDTH-1:0] rd_sel,
  output logic              wr_acc,
  output logic              rd_acc,
  output logic [PWIDTH-1:0] wr_ptr,
  output logic [PWIDTH-1:0] rd_ptr,
`ifdef MC_FIFO_CTRL_OCCUPANCY_EN
  input  logic [QWIDTH-1:0] occ_sel,
  output logic [PWIDTH:0]   occ_count,
`endif
  output logic [NUM_QUEUES-1:0] empty,
  output logic [NUM_QUEUES-1:0] full
);

  localparam logic [PWIDTH:0] FULL_COUNT = (PWIDTH+1)'(DEPTH);

  logic [PWIDTH-1:0]     head  [NUM_QUEUES];
  logic [PWIDTH-1:0]     tail  [NUM_QUEUES];
  logic [PWIDTH:0]       count [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] wr_hit;
  logic [NUM_QUEUES-1:0] rd_hit;

  // Flags come straight from the registered counts.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      empty[i] = (count[i] == '0);
      full[i]  = (count[i] == FULL_COUNT);
    end
  end

  // Flags are pre-edge, so on a full queue a same-cycle pop cannot make room
  // for the push, and on an empty queue a same-cycle push cannot feed the pop.
  assign wr_acc = wrreq & ~full[wr_sel];
  assign rd_acc = rdreq & ~empty[rd_sel];
  assign wr_ptr = tail[wr_sel];
  assign rd_ptr = head[rd_sel];

  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      wr_hit[i] = wr_acc & (wr_sel == QWIDTH'(i));
      rd_hit[i] = rd_acc & (rd_sel == QWIDTH'(i));
    end
  end

  // Pointers wrap naturally at DEPTH; a push and pop on one queue cancel in count.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (wr_hit[i]) tail[i] <= tail[i] + 1'b1;
        if (rd_hit[i]) head[i] <= head[i] + 1'b1;
        case ({wr_hit[i], rd_hit[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

`ifdef MC_FIFO_CTRL_OCCUPANCY_EN
  // Registered readout of the selected queue's pre-edge count.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) occ_count <= '0;
    else        occ_count <= count[occ_sel];
  end
`else
  // Without the readout, counts are only observable through empty/full.
`endif

endmodule

// File: rtl/mc_fifo_controller.sv
// mc_fifo_controller
// Multi-queue FIFO controller: NUM_QUEUES logical FIFOs statically carved out
// of one external simple-dual-port BRAM (queue ID forms the address MSBs).
// Optional feature macro: MC_FIFO_CTRL_OCCUPANCY_EN (adds occ_queue/occ_count).
// Ports:
//   clock, rst_n            clock and asynchronous active-low reset
//   wrreq, wrqueue, data    enqueue side
//   rdreq, rdqueue          dequeue side
//   q, q_valid              dequeued word, RD_LATENCY cycles after an accepted rdreq
//   empty, full             per-queue flag bitmaps
//   overflow, underflow     one-cycle pulses for dropped requests
//   bram_*                  write port, read address and read data of the BRAM
//   occ_queue, occ_count    registered occupancy of a chosen queue (macro only)
module mc_fifo_controller
  import mc_fifo_ctrl_pkg::*;
#(
  parameter  int DWIDTH     = 8,
  parameter  int DEPTH      = 2048,
  parameter  int NUM_QUEUES = 4,
  parameter  int RD_LATENCY = 1,
  localparam int QWIDTH     = calc_qwidth(NUM_QUEUES),
  localparam int PWIDTH     = $clog2(DEPTH),
  localparam int AWIDTH     = QWIDTH + PWIDTH
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  wrreq,
  input  logic [QWIDTH-1:0]     wrqueue,
  input  logic [DWIDTH-1:0]     data,
  input  logic                  rdreq,
  input  logic [QWIDTH-1:0]     rdqueue,
  output logic [DWIDTH-1:0]     q,
  output logic                  q_valid,
  output logic [NUM_QUEUES-1:0] empty,
  output logic [NUM_QUEUES-1:0] full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [DWIDTH-1:0]     bram_data,
  output logic [AWIDTH-1:0]     bram_wraddress,
  output logic                  bram_wren,
  output logic [AWIDTH-1:0]     bram_rdaddress,
`ifdef MC_FIFO_CTRL_OCCUPANCY_EN
  input  logic [QWIDTH-1:0]     occ_queue,
  output logic [PWIDTH:0]       occ_count,
`endif
  input  logic [DWIDTH-1:0]     bram_q
);

  if (DWIDTH < 1 || DWIDTH > FIFO_MAX_WIDTH) begin : g_bad_dwidth
    $error("mc_fifo_controller: DWIDTH %0d out of range", DWIDTH);
  end
  if (DEPTH < 2 || DEPTH > FIFO_MAX_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mc_fifo_controller: DEPTH %0d must be a power of two in 2..2^20", DEPTH);
  end
  if (NUM_QUEUES < 1 || NUM_QUEUES > MAX_QUEUES || (NUM_QUEUES & (NUM_QUEUES - 1)) != 0) begin : g_bad_queues
    $error("mc_fifo_controller: NUM_QUEUES %0d must be a power of two in 1..256", NUM_QUEUES);
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("mc_fifo_controller: RD_LATENCY %0d must be 1 or 2", RD_LATENCY);
  end

  logic                  wr_acc;
  logic                  rd_acc;
  logic [QWIDTH-1:0]     wr_sel;
  logic [QWIDTH-1:0]     rd_sel;
  logic [PWIDTH-1:0]     wr_ptr;
  logic [PWIDTH-1:0]     rd_ptr;
  logic [RD_LATENCY-1:0] vld_pipe;

  // With a single queue the select inputs are ignored and the address MSB is tied low.
  assign wr_sel = (NUM_QUEUES == 1) ? '0 : wrqueue;
  assign rd_sel = (NUM_QUEUES == 1) ? '0 : rdqueue;

  mc_fifo_ptr_bank #(
    .NUM_QUEUES (NUM_QUEUES),
    .DEPTH      (DEPTH),
    .QWIDTH     (QWIDTH),
    .PWIDTH     (PWIDTH)
  ) u_ptr_bank (
    .clock     (clock),
    .rst_n     (rst_n),
    .wrreq     (wrreq),
    .wr_sel    (wr_sel),
    .rdreq     (rdreq),
    .rd_sel    (rd_sel),
    .wr_acc    (wr_acc),
    .rd_acc    (rd_acc),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
`ifdef MC_FIFO_CTRL_OCCUPANCY_EN
    .occ_sel   ((NUM_QUEUES == 1) ? '0 : occ_queue),
    .occ_count (occ_count),
`endif
    .empty     (empty),
    .full      (full)
  );

  assign bram_wren      = wr_acc;
  assign bram_wraddress = {wr_sel, wr_ptr};
  assign bram_data      = data;
  assign bram_rdaddress = {rd_sel, rd_ptr};
  assign q              = bram_q;
  assign q_valid        = vld_pipe[RD_LATENCY-1];

  // q_valid tracks the BRAM's read latency; reset discards in-flight reads.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= RD_LATENCY'({vld_pipe, rd_acc});
  end

  // Drop reporting uses the same pre-edge flags as the accept logic.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wrreq & full[wr_sel];
      underflow <= rdreq & empty[rd_sel];
    end
  end

endmodule

// File: tb/tb_mc_fifo_controller.sv
// tb_mc_fifo_controller
// Scoreboard bench for mc_fifo_controller with a behavioural BRAM and a
// queue-based reference model of the logical FIFOs.
module tb_mc_fifo_controller;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int NQ    = 4;
  localparam int RDL   = 2;
  localparam int QW    = 2;
  localparam int PW    = 4;
  localparam int AW    = QW + PW;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          wrreq;
  logic [QW-1:0] wrqueue;
  logic [DW-1:0] data;
  logic          rdreq;
  logic [QW-1:0] rdqueue;
  logic [DW-1:0] q;
  logic          q_valid;
  logic [NQ-1:0] empty;
  logic [NQ-1:0] full;
  logic          overflow;
  logic          underflow;
  logic [DW-1:0] bram_data;
  logic [AW-1:0] bram_wraddress;
  logic          bram_wren;
  logic [AW-1:0] bram_rdaddress;
  logic [DW-1:0] bram_q;
`ifdef MC_FIFO_CTRL_OCCUPANCY_EN
  logic [QW-1:0] occ_queue;
  logic [PW:0]   occ_count;
  int            expOcc;
`endif

  always #5 clock = ~clock;

  mc_fifo_controller #(
    .DWIDTH     (DW),
    .DEPTH      (DEPTH),
    .NUM_QUEUES (NQ),
    .RD_LATENCY (RDL)
  ) dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .wrreq          (wrreq),
    .wrqueue        (wrqueue),
    .data           (data),
    .rdreq          (rdreq),
    .rdqueue        (rdqueue),
    .q              (q),
    .q_valid        (q_valid),
    .empty          (empty),
    .full           (full),
    .overflow       (overflow),
    .underflow      (underflow),
    .bram_data      (bram_data),
    .bram_wraddress (bram_wraddress),
    .bram_wren      (bram_wren),
    .bram_rdaddress (bram_rdaddress),
`ifdef MC_FIFO_CTRL_OCCUPANCY_EN
    .occ_queue      (occ_queue),
    .occ_count      (occ_count),
`endif
    .bram_q         (bram_q)
  );

  // Behavioural simple-dual-port BRAM with RDL cycles of read latency.
  logic [DW-1:0] mem [NQ*DEPTH];
  logic [DW-1:0] rdPipe [RDL];

  always @(posedge clock) begin
    if (bram_wren) mem[bram_wraddress] <= bram_data;
    rdPipe[0] <= mem[bram_rdaddress];
    for (int i = 1; i < RDL; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign bram_q = rdPipe[RDL-1];

  // Reference model: one plain queue per logical FIFO plus running push/pop totals.
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic [DW-1:0] fifoModel [NQ][$];
  int            pushTotal [NQ];
  int            popTotal  [NQ];
  exp_t          sb[$];
  logic          expOverflow;
  logic          expUnderflow;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every cycle the head of the scoreboard says whether q must be valid now.
  always @(negedge clock) begin
    logic expValid;
    exp_t e;
    expValid = (sb.size() > 0) && (sb[0].due <= cyc);
    check("q_valid", {31'd0, q_valid}, {31'd0, expValid});
    if (expValid) begin
      e = sb.pop_front();
      check("q_data", {24'd0, q}, {24'd0, e.data});
    end
  end

  function automatic void clearModel();
    for (int i = 0; i < NQ; i++) begin
      fifoModel[i].delete();
      pushTotal[i] = 0;
      popTotal[i]  = 0;
    end
    sb.delete();
    expOverflow  = 1'b0;
    expUnderflow = 1'b0;
`ifdef MC_FIFO_CTRL_OCCUPANCY_EN
    expOcc = 0;
`endif
  endfunction

  // Registered outputs against the model state left by the previous edge.
  task automatic checkOutput();
    logic [NQ-1:0] expEmpty;
    logic [NQ-1:0] expFull;
    for (int i = 0; i < NQ; i++) begin
      expEmpty[i] = (fifoModel[i].size() == 0);
      expFull[i]  = (fifoModel[i].size() == DEPTH);
    end
    check("empty", {28'd0, empty}, {28'd0, expEmpty});
    check("full", {28'd0, full}, {28'd0, expFull});
    check("overflow", {31'd0, overflow}, {31'd0, expOverflow});
    check("underflow", {31'd0, underflow}, {31'd0, expUnderflow});
`ifdef MC_FIFO_CTRL_OCCUPANCY_EN
    check("occ_count", {27'd0, occ_count}, 32'(expOcc));
`endif
  endtask

  // One clock cycle of stimulus: check registered state, drive, check the
  // combinational BRAM interface, then advance the model.
  task automatic applyStimulus(input logic wr, input logic [QW-1:0] wq, input logic [DW-1:0] d,
                               input logic rd, input logic [QW-1:0] rq);
    logic wasFull, wasEmpty, wrAcc, rdAcc;
    @(negedge clock);
    checkOutput();
    wrreq   = wr;
    wrqueue = wq;
    data    = d;
    rdreq   = rd;
    rdqueue = rq;
`ifdef MC_FIFO_CTRL_OCCUPANCY_EN
    occ_queue = rq;
`endif
    #1;
    wasFull  = (fifoModel[wq].size() == DEPTH);
    wasEmpty = (fifoModel[rq].size() == 0);
    wrAcc    = wr && !wasFull;
    rdAcc    = rd && !wasEmpty;
    check("bram_wren", {31'd0, bram_wren}, {31'd0, wrAcc});
    check("bram_wraddress", {26'd0, bram_wraddress}, (int'(wq) * DEPTH) + (pushTotal[wq] % DEPTH));
    check("bram_rdaddress", {26'd0, bram_rdaddress}, (int'(rq) * DEPTH) + (popTotal[rq] % DEPTH));
    if (wrAcc) check("bram_data", {24'd0, bram_data}, {24'd0, d});
    expOverflow  = wr && wasFull;
    expUnderflow = rd && wasEmpty;
`ifdef MC_FIFO_CTRL_OCCUPANCY_EN
    expOcc = fifoModel[rq].size();
`endif
    if (rdAcc) begin
      sb.push_back('{data: fifoModel[rq].pop_front(), due: cyc + RDL});
      popTotal[rq]++;
    end
    if (wrAcc) begin
      fifoModel[wq].push_back(d);
      pushTotal[wq]++;
    end
  endtask

  // Asynchronous reset landing while reads are still in flight.
  task automatic midReset();
    @(posedge clock);
    #2;
    rst_n = 1'b0;
    wrreq = 1'b0;
    rdreq = 1'b0;
    #1;
    check("q_valid_in_reset", {31'd0, q_valid}, 32'd0);
    check("empty_in_reset", {28'd0, empty}, 32'hF);
    check("full_in_reset", {28'd0, full}, 32'd0);
    clearModel();
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
  endtask

  initial begin
    int wrPct;
    int rdPct;
    rst_n   = 1'b0;
    wrreq   = 1'b0;
    wrqueue = '0;
    data    = '0;
    rdreq   = 1'b0;
    rdqueue = '0;
`ifdef MC_FIFO_CTRL_OCCUPANCY_EN
    occ_queue = '0;
`endif
    clearModel();
    repeat (3) @(negedge clock);
    rst_n = 1'b1;

    // Idle after reset.
    repeat (2) applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);

    // Fill queue 2 past full, then drain past empty.
    for (int i = 0; i <= DEPTH; i++) applyStimulus(1'b1, 2'd2, 8'(8'h40 + i), 1'b0, 2'd0);
    for (int i = 0; i <= DEPTH; i++) applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);

    // Interleave queues 0 and 3, then drain them alternately.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 2'd0, 8'(8'hA0 + i), 1'b0, 2'd0);
      applyStimulus(1'b1, 2'd3, 8'(8'h30 + i), 1'b0, 2'd0);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
    end

    // Queue 1 at count 5 under simultaneous push+pop; the pointers wrap many times.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd1, 8'(8'h10 + i), 1'b0, 2'd0);
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 2'd1, 8'(i), 1'b1, 2'd1);

    // Same on a full queue: the pop wins and the push is dropped.
    for (int i = 0; i < DEPTH - 5; i++) applyStimulus(1'b1, 2'd1, 8'(8'hC0 + i), 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd1, 8'(8'hE0 + i), 1'b1, 2'd1);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);

    // Pop on empty queue 0.
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);

    // Randomised traffic with shifting push/pop bias so queues reach both extremes.
    for (int p = 0; p < 12; p++) begin
      wrPct = (p % 3 == 0) ? 85 : ((p % 3 == 1) ? 15 : 50);
      rdPct = 100 - wrPct;
      for (int i = 0; i < 200; i++)
        applyStimulus($urandom_range(0, 99) < wrPct, 2'($urandom_range(0, NQ - 1)), 8'($urandom),
                      $urandom_range(0, 99) < rdPct, 2'($urandom_range(0, NQ - 1)));
    end

    // Reset in the middle of a read burst.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'd1, 8'(8'h70 + i), 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
    midReset();

    // More random traffic after the reset.
    for (int i = 0; i < 600; i++)
      applyStimulus($urandom_range(0, 1) == 1, 2'($urandom_range(0, NQ - 1)), 8'($urandom),
                    $urandom_range(0, 1) == 1, 2'($urandom_range(0, NQ - 1)));

    // Let outstanding reads return, then confirm nothing is left owed.
    repeat (RDL + 3) applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
